// File: rtl/legv8_ctrl_pkg.sv
// =====================================================================
// legv8_ctrl_pkg : shared types and encodings for the LEGv8 control FSM
// Rev 1.0
// =====================================================================
`default_nettype none

package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ and B carry immediate bits in the low opcode bits, so only a prefix is decoded
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_TARGET = 2'd2;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg2loc;
    logic       illegal_op;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/legv8_multicycle_control_if.sv
// =====================================================================
// legv8_multicycle_control_if : controller <-> datapath signal bundle
// Rev 1.0
// =====================================================================
`default_nettype none

interface legv8_multicycle_control_if;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        ALUOp1;
  logic        ALUOp0;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        reg2loc;
  logic        illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output ALUOp1, ALUOp0, alu_src_a, alu_src_b, pc_write, pc_write_cond,
           pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, reg2loc, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALUOp1, ALUOp0, alu_src_a, alu_src_b, pc_write, pc_write_cond,
           pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, reg2loc, illegal_op
  );
endinterface

`default_nettype wire

// File: rtl/legv8_opcode_decoder.sv
// =====================================================================
// legv8_opcode_decoder : classifies instruction[31:21] into control classes
// Rev 1.0
// =====================================================================
`default_nettype none

module legv8_opcode_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic        is_r,
  output logic        is_ld,
  output logic        is_st,
  output logic        is_cbz,
  output logic        is_b,
  output logic        is_illegal
);

  always_comb begin
    is_r       = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                 (opcode == OP_AND) || (opcode == OP_ORR);
    is_ld      = (opcode == OP_LDUR);
    is_st      = (opcode == OP_STUR);
    is_cbz     = (opcode[10:3] == OP_CBZ_PFX);
    is_b       = (opcode[10:5] == OP_B_PFX);
    is_illegal = !(is_r || is_ld || is_st || is_cbz || is_b);
  end

endmodule

`default_nettype wire

// File: rtl/legv8_multicycle_control.sv
// =====================================================================
// legv8_multicycle_control : multi-cycle LEGv8 main control FSM.
// Define CTRL_PERF_CNT_EN to add retired/cycle counters.  Rev 1.0
// =====================================================================
`default_nettype none

module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              ALUOp1,
    output logic              ALUOp0,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic [1:0]        pc_source,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              reg2loc,
    output logic              illegal_op
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
`endif
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;
    logic   w_is_r, w_is_ld, w_is_st, w_is_cbz, w_is_b, w_is_illegal;

    legv8_opcode_decoder u_dec (
        .opcode     (opcode),
        .is_r       (w_is_r),
        .is_ld      (w_is_ld),
        .is_st      (w_is_st),
        .is_cbz     (w_is_cbz),
        .is_b       (w_is_b),
        .is_illegal (w_is_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        unique case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.i_or_d    = 1'b0;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SRCB_IMM_SH;
                if (w_is_illegal)             w_next = S_ILLEGAL;
                else if (w_is_r)              w_next = S_EXEC_R;
                else if (w_is_ld || w_is_st)  w_next = S_MEM_ADDR;
                else if (w_is_cbz)            w_next = S_BRANCH;
                else                          w_next = S_JUMP;
            end
            S_EXEC_R: begin
                w_ctrl.alu_op    = ALUOP_RTYPE;
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_next           = S_WB_R;
            end
            S_WB_R: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b0;
                w_next            = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_next           = w_is_ld ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_next            = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.i_or_d    = 1'b1;
                w_ctrl.reg2loc   = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_op        = ALUOP_PASSB;
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_REG;
                w_ctrl.reg2loc       = 1'b1;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_next               = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_TARGET;
                w_next           = S_FETCH;
            end
            S_ILLEGAL: begin
                w_ctrl.illegal_op = 1'b1;
                w_next            = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign w_out = rst_n ? w_ctrl : '0;

    assign ALUOp1        = w_out.alu_op[1];
    assign ALUOp0        = w_out.alu_op[0];
    assign alu_src_a     = w_out.alu_src_a;
    assign alu_src_b     = w_out.alu_src_b;
    assign pc_write      = w_out.pc_write;
    assign pc_write_cond = w_out.pc_write_cond;
    assign pc_source     = w_out.pc_source;
    assign i_or_d        = w_out.i_or_d;
    assign mem_read      = w_out.mem_read;
    assign mem_write     = w_out.mem_write;
    assign ir_write      = w_out.ir_write;
    assign reg_write     = w_out.reg_write;
    assign mem_to_reg    = w_out.mem_to_reg;
    assign reg2loc       = w_out.reg2loc;
    assign illegal_op    = w_out.illegal_op;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
            r_cycles  <= '0;
        end else begin
            r_cycles <= r_cycles + CNT_W'(1);
            if ((r_state != S_FETCH) && (w_next == S_FETCH))
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired_cnt = r_retired;
    assign cycle_cnt   = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_legv8_multicycle_control.sv
// =====================================================================
// tb_legv8_multicycle_control : randomized self-checking bench against a
// per-instruction step model of the LEGv8 control sequence.  Rev 1.0
// =====================================================================
`default_nettype none

module tb_legv8_multicycle_control;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    legv8_multicycle_control_if bus ();

    logic [3:0] retired_cnt;
    logic [3:0] cycle_cnt;

    legv8_multicycle_control #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (bus.opcode),
        .zero          (bus.zero),
        .mem_ready     (bus.mem_ready),
        .ALUOp1        (bus.ALUOp1),
        .ALUOp0        (bus.ALUOp0),
        .alu_src_a     (bus.alu_src_a),
        .alu_src_b     (bus.alu_src_b),
        .pc_write      (bus.pc_write),
        .pc_write_cond (bus.pc_write_cond),
        .pc_source     (bus.pc_source),
        .i_or_d        (bus.i_or_d),
        .mem_read      (bus.mem_read),
        .mem_write     (bus.mem_write),
        .ir_write      (bus.ir_write),
        .reg_write     (bus.reg_write),
        .mem_to_reg    (bus.mem_to_reg),
        .reg2loc       (bus.reg2loc),
        .illegal_op    (bus.illegal_op)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired_cnt   (retired_cnt),
        .cycle_cnt     (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] mk(input int aop, input int sa, input int sb, input int pw,
                                       input int pwc, input int ps, input int iod, input int mr,
                                       input int mw, input int irw, input int rw, input int m2r,
                                       input int r2l, input int ill);
        return {2'(aop), 1'(sa), 2'(sb), 1'(pw), 1'(pwc), 2'(ps), 1'(iod), 1'(mr),
                1'(mw), 1'(irw), 1'(rw), 1'(m2r), 1'(r2l), 1'(ill)};
    endfunction

    function automatic logic [16:0] obs();
        return {bus.ALUOp1, bus.ALUOp0, bus.alu_src_a, bus.alu_src_b, bus.pc_write,
                bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.reg2loc, bus.illegal_op};
    endfunction

    function automatic int classify(input logic [10:0] op);
        logic [7:0] p8;
        logic [5:0] p6;
        p8 = op[10:3];
        p6 = op[10:5];
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return 0;
        if (op == 11'b11111000010) return 1;
        if (op == 11'b11111000000) return 2;
        if (p8 == 8'b10110100)     return 3;
        if (p6 == 6'b000101)       return 4;
        return 5;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [10:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 11'b10001011000;
            1: return 11'b11001011000;
            2: return ($urandom_range(0, 1) == 0) ? 11'b10001010000 : 11'b10101010000;
            3: return 11'b11111000010;
            4: return 11'b11111000000;
            5: return {8'b10110100, 3'($urandom)};
            6: return {6'b000101, 5'($urandom)};
            default: return 11'($urandom);
        endcase
    endfunction

    task automatic cyc(input logic rdy, input logic [16:0] exp, input string tag);
        bus.mem_ready = rdy;
        @(negedge clk);
        check(tag, 32'(obs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [10:0] op, input int fst, input int mst, input logic z);
        int c;
        c = classify(op);
        bus.opcode = op;
        bus.zero   = z;
        for (int i = 0; i <= fst; i++) begin
            logic r;
            r = (i == fst);
            cyc(r, mk(0,0,1,r,0,0,0,1,0,r,0,0,0,0), "fetch");
        end
        cyc(rb(), mk(0,0,3,0,0,0,0,0,0,0,0,0,0,0), "decode");
        case (c)
            0: begin
                cyc(rb(), mk(2,1,0,0,0,0,0,0,0,0,0,0,0,0), "exec_r");
                cyc(rb(), mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0), "wb_r");
            end
            1: begin
                cyc(rb(), mk(0,1,2,0,0,0,0,0,0,0,0,0,0,0), "ld_addr");
                for (int i = 0; i <= mst; i++)
                    cyc(i == mst, mk(0,0,0,0,0,0,1,1,0,0,0,0,0,0), "mem_rd");
                cyc(rb(), mk(0,0,0,0,0,0,0,0,0,0,1,1,0,0), "mem_wb");
            end
            2: begin
                cyc(rb(), mk(0,1,2,0,0,0,0,0,0,0,0,0,0,0), "st_addr");
                for (int i = 0; i <= mst; i++)
                    cyc(i == mst, mk(0,0,0,0,0,0,1,0,1,0,0,0,1,0), "mem_wr");
            end
            3: cyc(rb(), mk(1,1,0,0,1,1,0,0,0,0,0,0,1,0), "branch");
            4: cyc(rb(), mk(0,0,0,1,0,2,0,0,0,0,0,0,0,0), "jump");
            default: cyc(rb(), mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1), "illegal");
        endcase
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.opcode    = 11'b11111000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outs", 32'(obs()), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("reset_retired", 32'(retired_cnt), 32'd0);
        check("reset_cycles", 32'(cycle_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(11'b10001011000, 0, 0, 1'b0);
        run_instr(11'b11111000010, 0, 3, 1'b0);
        run_instr({8'b10110100, 3'b101}, 0, 0, 1'b1);
        run_instr(11'h7FF, 0, 0, 1'b0);
        run_instr(11'b11111000000, 1, 2, 1'b0);

        for (int n = 0; n < 80; n++)
            run_instr(rand_op(), $urandom_range(0, 2), $urandom_range(0, 2), rb());

        bus.opcode = 11'b11111000000;
        cyc(1'b1, mk(0,0,1,1,0,0,0,1,0,1,0,0,0,0), "rw_fetch");
        cyc(rb(),  mk(0,0,3,0,0,0,0,0,0,0,0,0,0,0), "rw_decode");
        cyc(rb(),  mk(0,1,2,0,0,0,0,0,0,0,0,0,0,0), "rw_addr");
        cyc(1'b0,  mk(0,0,0,0,0,0,1,0,1,0,0,0,1,0), "rw_wait");
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_wr_outs", 32'(obs()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 16; n++)
            run_instr({6'b000101, 5'($urandom)}, 0, 0, rb());
`ifdef CTRL_PERF_CNT_EN
        check("retired_wrap", 32'(retired_cnt), 32'd0);
        check("cycles_wrap", 32'(cycle_cnt), 32'd0);
`endif
        cyc(1'b0, mk(0,0,1,0,0,0,0,1,0,0,0,0,0,0), "fetch_stall_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
